// File: rtl/ex_stage_alu_mdu_pkg.sv
// Shared constants and types for the EX stage: ALUOp codes, funct encodings,
// forwarding selects and the multiplier state enum.
package ex_stage_alu_mdu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // Full {funct7, funct3} encodings for the R-type group
    localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
    localparam logic [9:0] FUNCT_XOR = 10'b0000000_100;
    localparam logic [9:0] FUNCT_SLL = 10'b0000000_001;
    localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
    localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
    localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

    localparam logic [2:0] FUNCT3_ADDI = 3'b000;
    localparam logic [2:0] FUNCT3_SRAI = 3'b101;
    localparam logic [6:0] FUNCT7_SRAI = 7'b0100000;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/ex_stage_alu_mdu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits
// of the product kept in the accumulator and held until the pipeline releases it.
module mul_iter
    import ex_stage_alu_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_start,
    input  logic            i_cpuStall,
    input  logic [XLEN-1:0] i_opA,
    input  logic [XLEN-1:0] i_opB,
    output logic            o_idle,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    mul_state_e        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;

    // Only the low half of the product is needed, so the multiplicand never
    // has to grow beyond XLEN bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= MUL_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_opA;
                        r_mplier <= i_opB;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(MUL_CYCLES - 1)) begin
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (!i_cpuStall) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign o_idle    = (r_state == MUL_IDLE);
    assign o_busy    = (r_state == MUL_BUSY);
    assign o_done    = (r_state == MUL_DONE);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage_alu_mdu.sv
// Execute stage: operand forwarding, ALU control decode and single-cycle ALU,
// with MUL handed to the iterative multiplier while the pipeline is stalled.
module ex_stage_alu_mdu
    import ex_stage_alu_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_stall_i,
    input  logic            RegWrite_i,
    input  logic [1:0]      ALUOp_i,
    input  logic            ALUSrc_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [XLEN-1:0] ImmGen_i,
    input  logic [9:0]      funct_i,
    input  logic [1:0]      fwd_a_i,
    input  logic [1:0]      fwd_b_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic [XLEN-1:0] memwb_data_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic            mul_stall_o
);

    logic [XLEN-1:0] w_opA;
    logic [XLEN-1:0] w_fwdB;
    logic [XLEN-1:0] w_opB;
    logic [XLEN-1:0] w_aluResult;
    logic [XLEN-1:0] w_product;
    logic [4:0]      w_shamt;
    logic            w_mulDet;
    logic            w_mulIdle;
    logic            w_mulBusy;
    logic            w_mulDone;

    // Select 11 is unused by the hazard unit and falls back to the register file
    always_comb begin
        case (fwd_a_i)
            FWD_EXMEM: w_opA = exmem_result_i;
            FWD_MEMWB: w_opA = memwb_data_i;
            default:   w_opA = data1_i;
        endcase
        case (fwd_b_i)
            FWD_EXMEM: w_fwdB = exmem_result_i;
            FWD_MEMWB: w_fwdB = memwb_data_i;
            default:   w_fwdB = data2_i;
        endcase
    end

    assign w_opB        = ALUSrc_i ? ImmGen_i : w_fwdB;
    assign store_data_o = w_fwdB;
    assign w_shamt      = w_opB[4:0];

    // MUL yields 0 here; its result comes from the multiplier in DONE
    always_comb begin
        w_aluResult = '0;
        case (ALUOp_i)
            ALUOP_ADD: w_aluResult = w_opA + w_opB;
            ALUOP_SUB: w_aluResult = w_opA - w_opB;
            ALUOP_R: begin
                case (funct_i)
                    FUNCT_AND: w_aluResult = w_opA & w_opB;
                    FUNCT_XOR: w_aluResult = w_opA ^ w_opB;
                    FUNCT_SLL: w_aluResult = w_opA << w_shamt;
                    FUNCT_ADD: w_aluResult = w_opA + w_opB;
                    FUNCT_SUB: w_aluResult = w_opA - w_opB;
                    default:   w_aluResult = '0;
                endcase
            end
            ALUOP_I: begin
                if (funct_i[2:0] == FUNCT3_ADDI) begin
                    w_aluResult = w_opA + w_opB;
                end else if (funct_i[2:0] == FUNCT3_SRAI && funct_i[9:3] == FUNCT7_SRAI) begin
                    w_aluResult = $signed(w_opA) >>> w_shamt;
                end
            end
            default: w_aluResult = '0;
        endcase
    end

    assign w_mulDet = RegWrite_i && (ALUOp_i == ALUOP_R) && (funct_i == FUNCT_MUL);

    mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mulIter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_start    (w_mulDet),
        .i_cpuStall (cpu_stall_i),
        .i_opA      (w_opA),
        .i_opB      (w_opB),
        .o_idle     (w_mulIdle),
        .o_busy     (w_mulBusy),
        .o_done     (w_mulDone),
        .o_product  (w_product)
    );

    // Stall rises in the detect cycle itself and drops the moment reset hits
    assign mul_stall_o  = !rst_i && ((w_mulIdle && w_mulDet) || w_mulBusy);
    assign alu_result_o = w_mulDone ? w_product : w_aluResult;

endmodule

// File: tb/tb_ex_stage_alu_mdu.sv
// Directed bench for the EX stage: a vector table for single-cycle ops and
// hand-written sequences for MUL latency, result hold and reset abort.
module tb_ex_stage_alu_mdu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_stall_i;
    logic        RegWrite_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [31:0] ImmGen_i;
    logic [9:0]  funct_i;
    logic [1:0]  fwd_a_i;
    logic [1:0]  fwd_b_i;
    logic [31:0] exmem_result_i;
    logic [31:0] memwb_data_i;
    logic [31:0] alu_result_o;
    logic [31:0] store_data_o;
    logic        mul_stall_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        regWrite;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic [9:0]  funct;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [31:0] exmem;
        logic [31:0] memwb;
        logic [31:0] expResult;
        logic [31:0] expStore;
        logic        expStall;
    } vec_t;

    localparam int NUM_VECS = 15;
    vec_t vecs [NUM_VECS];

    ex_stage_alu_mdu #(
        .XLEN       (32),
        .MUL_CYCLES (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_stall_i    (cpu_stall_i),
        .RegWrite_i     (RegWrite_i),
        .ALUOp_i        (ALUOp_i),
        .ALUSrc_i       (ALUSrc_i),
        .data1_i        (data1_i),
        .data2_i        (data2_i),
        .ImmGen_i       (ImmGen_i),
        .funct_i        (funct_i),
        .fwd_a_i        (fwd_a_i),
        .fwd_b_i        (fwd_b_i),
        .exmem_result_i (exmem_result_i),
        .memwb_data_i   (memwb_data_i),
        .alu_result_o   (alu_result_o),
        .store_data_o   (store_data_o),
        .mul_stall_o    (mul_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        RegWrite_i     = v.regWrite;
        ALUOp_i        = v.aluOp;
        ALUSrc_i       = v.aluSrc;
        funct_i        = v.funct;
        fwd_a_i        = v.fwdA;
        fwd_b_i        = v.fwdB;
        data1_i        = v.data1;
        data2_i        = v.data2;
        ImmGen_i       = v.imm;
        exmem_result_i = v.exmem;
        memwb_data_i   = v.memwb;
    endtask

    task automatic driveMul(input logic [31:0] a, input logic [31:0] b);
        RegWrite_i = 1'b1;
        ALUOp_i    = 2'b10;
        ALUSrc_i   = 1'b0;
        funct_i    = 10'b0000001_000;
        fwd_a_i    = 2'b00;
        fwd_b_i    = 2'b00;
        data1_i    = a;
        data2_i    = b;
    endtask

    // Counts stall samples from the detect cycle on, scrambling the operands
    // after capture; returns at the first sample with the stall low.
    task automatic countStall(output int stallCount);
        int guard = 0;
        stallCount = 0;
        while (mul_stall_o === 1'b1 && guard < 100) begin
            stallCount++;
            guard++;
            @(negedge clk_i);
            data1_i = 32'hDEAD_BEEF;
            data2_i = 32'h1234_5678;
            #2;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int stallCount;

        //            rw    op     src   funct          fa     fb     data1          data2          imm            exmem      memwb      result         store          stall
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 10'b0000000_111, 2'b00, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,         32'h0,     32'h0,     32'h00F0_00F0, 32'h0FF0_0FF0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 1'b1, 10'b0100000_101, 2'b00, 2'b00, 32'h8000_0000, 32'h0000_1234, 32'h0000_0404, 32'h0,     32'h0,     32'hF800_0000, 32'h0000_1234, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 10'b0000000_000, 2'b10, 2'b01, 32'h0000_0099, 32'h0000_0088, 32'h0,         32'h5,     32'h7,     32'h0000_000C, 32'h0000_0007, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 10'b0000000_000, 2'b11, 2'b11, 32'h0000_0003, 32'h0000_0004, 32'h0,         32'h64,    32'hC8,    32'h0000_0007, 32'h0000_0004, 1'b0};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 10'b0000000_100, 2'b00, 2'b00, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,         32'h0,     32'h0,     32'hF00F_F00F, 32'h0F0F_0F0F, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 10'b0000000_001, 2'b00, 2'b00, 32'h0000_0001, 32'h0000_0024, 32'h0,         32'h0,     32'h0,     32'h0000_0010, 32'h0000_0024, 1'b0};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 10'b0100000_000, 2'b00, 2'b00, 32'h0000_0005, 32'h0000_0007, 32'h0,         32'h0,     32'h0,     32'hFFFF_FFFE, 32'h0000_0007, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 10'b0000000_000, 2'b00, 2'b00, 32'h0000_000A, 32'h0000_0003, 32'h0,         32'h0,     32'h0,     32'h0000_0007, 32'h0000_0003, 1'b0};
        vecs[8]  = '{1'b1, 2'b00, 1'b1, 10'b0000000_010, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'h0000_00AB, 32'h0000_0001, 32'h0,     32'h0,     32'h0000_0000, 32'h0000_00AB, 1'b0};
        vecs[9]  = '{1'b1, 2'b11, 1'b1, 10'b0000000_000, 2'b00, 2'b00, 32'h0000_000A, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,     32'h0,     32'h0000_0006, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 10'b1111111_111, 2'b00, 2'b00, 32'h1234_5678, 32'h1111_1111, 32'h0,         32'h0,     32'h0,     32'h0000_0000, 32'h1111_1111, 1'b0};
        vecs[11] = '{1'b1, 2'b11, 1'b1, 10'b0000000_101, 2'b00, 2'b00, 32'h8000_0000, 32'h0,         32'h0000_0004, 32'h0,     32'h0,     32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 10'b0000001_000, 2'b00, 2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0,         32'h0,     32'h0,     32'h0000_0000, 32'h0000_0007, 1'b0};
        vecs[13] = '{1'b1, 2'b00, 1'b1, 10'b0000000_000, 2'b00, 2'b10, 32'h0000_0001, 32'h0000_0077, 32'h0000_0002, 32'h55,    32'h0,     32'h0000_0003, 32'h0000_0055, 1'b0};
        vecs[14] = '{1'b1, 2'b11, 1'b1, 10'b0100000_101, 2'b00, 2'b00, 32'h8000_0000, 32'h0,         32'h0000_041F, 32'h0,     32'h0,     32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        rst_i          = 1'b1;
        cpu_stall_i    = 1'b0;
        RegWrite_i     = 1'b0;
        ALUOp_i        = 2'b00;
        ALUSrc_i       = 1'b0;
        data1_i        = '0;
        data2_i        = '0;
        ImmGen_i       = '0;
        funct_i        = '0;
        fwd_a_i        = 2'b00;
        fwd_b_i        = 2'b00;
        exmem_result_i = '0;
        memwb_data_i   = '0;
        #3;
        checkOutput("reset alu_result", alu_result_o, 32'h0);
        checkOutput("reset store_data", store_data_o, 32'h0);
        checkOutput("reset mul_stall", {31'b0, mul_stall_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d result", i), alu_result_o, vecs[i].expResult);
            checkOutput($sformatf("vec%0d store", i), store_data_o, vecs[i].expStore);
            checkOutput($sformatf("vec%0d stall", i), {31'b0, mul_stall_o}, {31'b0, vecs[i].expStall});
        end

        // MUL with the cache stall held high throughout; DONE must wait for release
        @(negedge clk_i);
        cpu_stall_i = 1'b1;
        driveMul(32'hFFFF_FFFF, 32'h0000_0003);
        #2;
        countStall(stallCount);
        checkOutput("mul1 stall cycles", 32'(stallCount), 32'd33);
        checkOutput("mul1 product", alu_result_o, 32'hFFFF_FFFD);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            #2;
            checkOutput($sformatf("mul1 hold%0d product", k), alu_result_o, 32'hFFFF_FFFD);
            checkOutput($sformatf("mul1 hold%0d stall", k), {31'b0, mul_stall_o}, 32'h0);
        end
        @(negedge clk_i);
        cpu_stall_i = 1'b0;
        #2;
        checkOutput("mul1 release product", alu_result_o, 32'hFFFF_FFFD);
        @(negedge clk_i);
        RegWrite_i = 1'b1;
        ALUOp_i    = 2'b00;
        ALUSrc_i   = 1'b0;
        funct_i    = 10'b0;
        data1_i    = 32'h2;
        data2_i    = 32'h3;
        #2;
        checkOutput("after mul add result", alu_result_o, 32'h5);
        checkOutput("after mul stall", {31'b0, mul_stall_o}, 32'h0);

        // Reset lands in the middle of BUSY; the aborted product must vanish
        @(negedge clk_i);
        driveMul(32'hFFFF_FFFF, 32'h0000_0003);
        #2;
        stallCount = 0;
        while (mul_stall_o === 1'b1 && stallCount < 11) begin
            stallCount++;
            @(negedge clk_i);
            #2;
        end
        checkOutput("abort stall before reset", {31'b0, mul_stall_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        checkOutput("abort stall in reset", {31'b0, mul_stall_o}, 32'h0);
        checkOutput("abort result in reset", alu_result_o, 32'h0);
        RegWrite_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        checkOutput("abort stall after reset", {31'b0, mul_stall_o}, 32'h0);
        @(negedge clk_i);
        driveMul(32'h0000_0006, 32'h0000_0007);
        #2;
        countStall(stallCount);
        checkOutput("mul2 stall cycles", 32'(stallCount), 32'd33);
        checkOutput("mul2 product", alu_result_o, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_alu_mdu.md
# ex_stage_alu_mdu

Execute stage of the five-stage RISC-V pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs: control bits, register operands, immediate and funct field. It applies EX/MEM and MEM/WB forwarding, decodes ALU control, and computes single-cycle results combinationally. MUL runs on an iterative 32-cycle shift-add multiplier, and the block raises a pipeline stall while that multiplier is busy.

## Interface
Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, number of multiplier iterations (must equal XLEN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_stall_i  in  1  external (cache) stall; when high, the pipeline does not advance
- RegWrite_i  in  1  from ID/EX; gates MUL detection
- ALUOp_i  in  2  from ID/EX
- ALUSrc_i  in  1  from ID/EX; 1 selects ImmGen_i as operand B
- data1_i, data2_i  in  XLEN  rs1/rs2 register values from ID/EX
- ImmGen_i  in  XLEN  sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- fwd_a_i, fwd_b_i  in  2  forwarding select for rs1/rs2
- exmem_result_i  in  XLEN  ALU result held in EX/MEM
- memwb_data_i  in  XLEN  write-back data from MEM/WB
- alu_result_o  out  XLEN  result to EX/MEM
- store_data_o  out  XLEN  forwarded rs2 value to EX/MEM
- mul_stall_o  out  1  high while a MUL is in progress; ORed with the cache stall at top level

## Operation
- Forwarding, applied independently to A and B:
  - 00 → data1_i / data2_i
  - 10 → exmem_result_i
  - 01 → memwb_data_i
  - 11 → treated as 00
- Operand B is ImmGen_i if ALUSrc_i is set, else the forwarded rs2 value.
- store_data_o always carries the forwarded rs2 value.
- ALUOp decode:
  - 00 → add (lw/sw)
  - 01 → sub
  - 10 → R-type:
    - funct 0000000_111 → and
    - funct 0000000_100 → xor
    - funct 0000000_001 → sll, shift amount B[4:0]
    - funct 0000000_000 → add
    - funct 0100000_000 → sub
    - funct 0000001_000 → mul
  - 11 → I-type:
    - funct3 000 → addi
    - funct3 101 with funct7 0100000 → srai, arithmetic shift by B[4:0]
  - Any other combination → result 0.
- Arithmetic wraps modulo 2^32. MUL returns the low 32 bits of the product; sign is irrelevant for the low half.
- A MUL is detected when RegWrite_i=1, ALUOp_i=10 and funct_i=0000001_000.
- Multiplier FSM states are IDLE, BUSY and DONE:
  - IDLE: on a MUL, capture the forwarded A and B, clear the accumulator, set the counter to 0 and go to BUSY. mul_stall_o=1 combinationally in this same cycle.
  - BUSY: per cycle, if multiplier bit0 is set then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++. After the iteration with counter == MUL_CYCLES-1, go to DONE. mul_stall_o=1 throughout.
  - DONE: mul_stall_o=0 and alu_result_o = accumulator. Go to IDLE when cpu_stall_i=0; otherwise hold DONE and the result.
- Non-MUL ops in IDLE produce their result combinationally with mul_stall_o=0.
- cpu_stall_i has no effect on IDLE or BUSY progress.

## Timing
- Non-MUL ops: 0-cycle combinational latency.
- MUL: mul_stall_o is high for exactly 33 cycles (detect cycle + 32 BUSY). The result is valid in the 34th cycle (DONE), and EX/MEM latches it on the first DONE edge with cpu_stall_i=0.
- Back-to-back MULs: DONE → IDLE, then the next MUL is detected in the following cycle.
- Operands are captured at detection, so later changes on the forwarding sources do not affect the product.
- Reset, or reset mid-MUL:
  - state is IDLE, the counter and accumulator are 0, mul_stall_o=0 immediately (asynchronous);
  - the aborted MUL is discarded;
  - alu_result_o and store_data_o follow their inputs combinationally, giving 0 with all inputs 0.

## Structure
- Shared package holds:
  - ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I);
  - funct constants for and, xor, sll, add, sub, mul, srai;
  - forwarding select codes;
  - the multiplier state enum.
- Sub-module mul_iter contains the FSM, counter, accumulator and shift registers. Its ports are start, operands, busy, done and product. Forwarding muxes and the ALU remain in the top module.

## Test plan
- ALUOp 10, funct and, data1=0xF0F0_F0F0, data2=0x0FF0_0FF0, fwd 00 → alu_result_o=0x00F0_00F0 in the same cycle; mul_stall_o=0.
- ALUOp 11, srai, data1=0x8000_0000, Imm=0x0000_0404 (funct7 0100000, shamt 4), ALUSrc=1 → 0xF800_0000.
- fwd_a=10 with exmem=5, fwd_b=01 with memwb=7, add → 12; fwd 11 with data1=3, data2=4 → 7.
- MUL 0xFFFF_FFFF × 3 → mul_stall_o high for 33 cycles, then DONE with result 0xFFFF_FFFD; with cpu_stall_i high for 2 extra cycles, the result is held until release.
- MUL with RegWrite_i=0 → no stall, result 0 path (bubble).
- rst_i asserted at BUSY cycle 10 → mul_stall_o=0 immediately and state IDLE; a fresh MUL 6×7 then yields 42 after 33 stall cycles.
